// File: rtl/sd_cmd_tx.sv
// SD command-line transmitter: serialises a 48-bit command frame with SD_CLK,
// feeding the first 40 bits to an external CRC7 unit and appending its result.
module sd_cmd_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [5:0]  CMD_INDEX,
  input  logic [31:0] CMD_ARG,
  output logic        BUSY,
  output logic        DONE,
  output logic        SD_CLK,
  output logic        SD_CMD,
  output logic        SD_CMD_OE,
  output logic        CRC_BITVAL,
  output logic        CRC_BITSTRB,
  output logic        CRC_ENABLE,
  output logic        CRC_CLEAR,
  input  logic [6:0]  CRC_VALUE
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

  typedef enum logic [2:0] {IDLE, CLR, BODY, CRC, ENDB} state_t;

  state_t        state, state_n;
  logic [5:0]    bitcnt, bitcnt_n;
  logic [DW-1:0] div, div_n;
  logic [39:0]   frame, frame_n;
  logic [6:0]    crc_r, crc_n;
  logic [5:0]    body_idx;
  logic [2:0]    crc_idx;
  logic          busy_n, done_n, sdclk_n, sdcmd_n, oe_n;
  logic          bitval_n, strb_n, en_n, clr_n;

  // Next-state logic; outputs are derived from the next-cycle view
  // (state_n/bitcnt_n/div_n) so that every output can be registered.
  always_comb begin
    state_n  = state;
    bitcnt_n = bitcnt;
    div_n    = div;
    frame_n  = frame;
    crc_n    = crc_r;
    done_n   = 1'b0;
    case (state)
      IDLE: if (START) begin
        state_n = CLR;
        frame_n = {1'b0, 1'b1, CMD_INDEX, CMD_ARG};
      end
      CLR: begin
        state_n  = BODY;
        bitcnt_n = '0;
        div_n    = '0;
      end
      default: begin
        if (div == DIV_LAST) begin
          div_n = '0;
          if (bitcnt == 6'd47) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            bitcnt_n = bitcnt + 6'd1;
            state_n  = (bitcnt_n < 6'd40) ? BODY :
                       (bitcnt_n < 6'd47) ? CRC  : ENDB;
          end
        end else begin
          div_n = div + DW'(1);
        end
      end
    endcase

    // Capture the CRC once, on entry to bit 40; the last strobe was at
    // divider=1 of bit 39 so the external unit has long since settled.
    if (state_n == CRC && bitcnt_n == 6'd40 && div_n == '0)
      crc_n = CRC_VALUE;

    body_idx = 6'd39 - bitcnt_n;
    crc_idx  = 3'(6'd46 - bitcnt_n);

    busy_n   = 1'b0;
    oe_n     = 1'b0;
    sdcmd_n  = 1'b1;
    sdclk_n  = 1'b0;
    bitval_n = 1'b0;
    strb_n   = 1'b0;
    en_n     = 1'b0;
    clr_n    = 1'b0;
    case (state_n)
      CLR: begin
        busy_n = 1'b1;
        oe_n   = 1'b1;
        clr_n  = 1'b1;
      end
      BODY: begin
        busy_n   = 1'b1;
        oe_n     = 1'b1;
        sdclk_n  = (div_n >= DIV_HALF);
        sdcmd_n  = frame_n[body_idx];
        bitval_n = frame_n[body_idx];
        en_n     = 1'b1;
        strb_n   = (div_n == DW'(1));
      end
      CRC: begin
        busy_n  = 1'b1;
        oe_n    = 1'b1;
        sdclk_n = (div_n >= DIV_HALF);
        sdcmd_n = crc_n[crc_idx];
      end
      ENDB: begin
        busy_n  = 1'b1;
        oe_n    = 1'b1;
        sdclk_n = (div_n >= DIV_HALF);
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      bitcnt      <= '0;
      div         <= '0;
      frame       <= '0;
      crc_r       <= '0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      SD_CLK      <= 1'b0;
      SD_CMD      <= 1'b1;
      SD_CMD_OE   <= 1'b0;
      CRC_BITVAL  <= 1'b0;
      CRC_BITSTRB <= 1'b0;
      CRC_ENABLE  <= 1'b0;
      CRC_CLEAR   <= 1'b1;
    end else begin
      state       <= state_n;
      bitcnt      <= bitcnt_n;
      div         <= div_n;
      frame       <= frame_n;
      crc_r       <= crc_n;
      BUSY        <= busy_n;
      DONE        <= done_n;
      SD_CLK      <= sdclk_n;
      SD_CMD      <= sdcmd_n;
      SD_CMD_OE   <= oe_n;
      CRC_BITVAL  <= bitval_n;
      CRC_BITSTRB <= strb_n;
      CRC_ENABLE  <= en_n;
      CRC_CLEAR   <= clr_n;
    end
  end

endmodule
